sipo_deframer: RTL and testbench
================================

# sipo_deframer

Serial-to-parallel receive stage. It sits directly downstream of the `shift_reg` serial output. It samples a framed, LSB-first bitstream one bit per enable strobe: start bit 0, N data bits, optional parity bit, stop bit 1. It presents each complete word on a parallel port with a valid/ready handshake and a one-word holding buffer, and flags framing, parity and overrun faults.

## Interface
- `N`, default 4: data bits per frame; legal range 2..16.
- `clk` input 1: single clock; all state updates on posedge.
- `res_n` input 1: asynchronous, active-low reset.
- `en` input 1: bit strobe; `din` is sampled only on a posedge where `en`=1.
- `din` input 1: serial input; connects to the `shift_reg` `dout`.
- `dout` output N: received word; stable while `dout_valid`=1.
- `dout_valid` output 1: word available in the holding register.
- `dout_ready` input 1: consumer accepts; transfer occurs on a posedge with `dout_valid`=1 and `dout_ready`=1.
- `busy` output 1: frame reception in progress (state ≠ IDLE).
- `frame_err` output 1: one-cycle pulse when the stop bit was sampled as 0.
- `par_err` output 1: one-cycle pulse on a parity mismatch. Tied to 0 when parity is compiled out.
- `overrun` output 1: one-cycle pulse when a good frame is dropped because the buffer is full.

## Operation
- Reset (`res_n`=0, asynchronous): state=IDLE, bit counter=0, shift register=0, `dout`=0, `dout_valid`=0, `busy`=0, all error pulses=0.
- The FSM advances only on sampled bits (`en`=1). With `en`=0 it holds its state, except for handshake and pulse clearing.
- IDLE: sampled `din`=0 → DATA, counter=0. Sampled `din`=1 → stay in IDLE (line idle).
- DATA: each sampled bit is shifted in at the MSB end (LSB-first arrival). The counter increments. After the N-th bit, go to PARITY if compiled in, else STOP.
- PARITY: sample the parity bit and latch the mismatch. Next state: STOP.
- STOP:
  - Sampled `din`=1 with no parity mismatch → frame good → IDLE.
  - Sampled `din`=0 → `frame_err` pulse, word discarded → IDLE. A stop=0 bit is not reinterpreted as a start bit.
  - Parity mismatch with stop=1 → `par_err` pulse, word discarded → IDLE.
- Good-frame commit:
  - If the buffer is empty, or is being emptied in the same cycle (`dout_valid`&`dout_ready`), load `dout` and set `dout_valid`=1.
  - Otherwise pulse `overrun`, drop the new word, and keep the old word and `dout_valid`.
- Handshake:
  - `dout_valid` clears on a transfer, unless a commit occurs in the same cycle; in that case it stays 1 with the new word.
  - `dout` never changes while `dout_valid`=1 without a transfer.
- Back-to-back frames are legal: a start bit may be sampled on the strobe right after the stop bit.

## Timing
- Frame length is N+2 strobes (N+3 with parity).
- `dout`/`dout_valid` update on the same posedge that samples the stop bit. That is 0 cycles of latency after the stop-bit edge, and outputs are registered.
- `frame_err`, `par_err` and `overrun` are high for exactly one `clk` cycle following the stop-bit edge, regardless of `en`.
- `busy` goes to 1 on the edge that samples the start bit and to 0 on the edge that samples the stop bit.
- Reset mid-frame aborts the frame immediately. No pulse is emitted, and the partial word is lost.
- `dout_ready` is ignored when `dout_valid`=0.

## Configuration
- `SIPO_PARITY_EN` defined:
  - An even-parity bit follows the data bits.
  - The PARITY state exists.
  - A frame is N+3 strobes.
  - `par_err` is active.
- `SIPO_PARITY_EN` undefined:
  - No PARITY state.
  - A frame is N+2 strobes.
  - `par_err` is constant 0.

## Test plan
All scenarios use N=4 and `en`=1 every cycle, without parity unless noted.
1. Reset, then `din`=1 for 10 cycles → `busy`=0, `dout_valid`=0, no pulses. Assert `res_n`=0 asynchronously mid-cycle → all outputs 0 before the next posedge.
2. Frame 0,1,1,0,1,1 (data 4'b1011 LSB-first), `dout_ready`=1 → `dout`=4'b1011 and `dout_valid`=1 for one cycle after the stop edge; `busy` high for 5 cycles. Repeat back-to-back for 4'b0101 and 4'b1010.
3. `dout_ready`=0, send 4'b0001, then 4'b1000 → first word held with `dout_valid`=1; one `overrun` pulse on the second stop edge; `dout` stays 4'b0001. Raise `dout_ready` in the same cycle as the third frame's stop edge → `dout`=third word, `dout_valid` stays 1.
4. Frame with stop bit 0 → one `frame_err` pulse, `dout_valid` unchanged. Next idle-then-start frame 4'b1111 is received correctly.
5. Assert `res_n`=0 after 2 data bits, release, send 4'b0110 → exactly one word 4'b0110, no error pulses.
6. With `SIPO_PARITY_EN`: 4'b1011 with parity bit 1 → accepted. Same data with parity bit 0 → one `par_err` pulse, no `dout_valid`.

Source files
------------

// File: rtl/sipo_deframer.sv
// sipo_deframer: LSB-first framed serial receiver with a one-word valid/ready holding buffer.
// Define SIPO_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module sipo_deframer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         res_n,
  input  logic         en,
  input  logic         din,
  output logic [N-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         busy,
  output logic         frame_err,
  output logic         par_err,
  output logic         overrun
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;
`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, STOP, PARITY} state_t;
  localparam state_t AFTER_DATA = PARITY;
  logic r_par;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
  localparam state_t AFTER_DATA = STOP;
  assign par_err = 1'b0;
`endif
  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_shift;
  logic           w_last;
  logic           w_take;
  assign w_last = r_cnt == CW'(N - 1);
  // A commit may reuse the buffer when it is being drained on the same edge
  assign w_take = !dout_valid || dout_ready;
  assign busy   = r_state != IDLE;
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
      r_par      <= 1'b0;
      par_err    <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef SIPO_PARITY_EN
      par_err   <= 1'b0;
`endif
      if (dout_valid && dout_ready)
        dout_valid <= 1'b0;
      if (en) begin
        case (r_state)
          IDLE: begin
            r_cnt   <= '0;
            r_state <= din ? IDLE : DATA;
          end
          DATA: begin
            r_shift <= {din, r_shift[N-1:1]};
            r_cnt   <= r_cnt + CW'(1);
            r_state <= w_last ? AFTER_DATA : DATA;
          end
`ifdef SIPO_PARITY_EN
          PARITY: begin
            r_par   <= din ^ (^r_shift);
            r_state <= STOP;
          end
`endif
          STOP: begin
            r_state <= IDLE;
            if (!din)
              frame_err <= 1'b1;
`ifdef SIPO_PARITY_EN
            else if (r_par)
              par_err <= 1'b1;
`endif
            else if (w_take) begin
              dout       <= r_shift;
              dout_valid <= 1'b1;
            end else
              overrun <= 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sipo_deframer.sv
// tb_sipo_deframer: directed checks of framing, handshake, overrun, error pulses and reset for N=4.
module tb_sipo_deframer;
  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic       en = 1'b1;
  logic       din = 1'b1;
  logic       dout_ready = 1'b0;
  logic [3:0] dout;
  logic       dout_valid, busy, frame_err, par_err, overrun;
  int tests = 0;
  int fails = 0;

  sipo_deframer #(.N(4)) dut (
    .clk(clk), .res_n(res_n), .en(en), .din(din),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .frame_err(frame_err), .par_err(par_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one bit at the negedge, let the posedge sample it, observe at the next negedge
  task automatic send_bit(input logic b);
    din = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic frame(input logic [3:0] d, input logic stop, input logic rdy, input logic pflip);
    send_bit(1'b0);
    chk("busy_start", busy, 1);
    for (int i = 0; i < 4; i++) begin
      send_bit(d[i]);
      chk("busy_data", busy, 1);
    end
`ifdef SIPO_PARITY_EN
    send_bit((^d) ^ pflip);
    chk("busy_par", busy, 1);
`endif
    dout_ready = rdy;
    send_bit(stop);
    chk("busy_stop", busy, 0);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    res_n = 1'b1;
    // 1: idle line
    for (int i = 0; i < 10; i++) begin
      send_bit(1'b1);
      chk("idle_busy", busy, 0);
      chk("idle_pulses", {dout_valid, frame_err, par_err, overrun}, 0);
    end
    // 2: back-to-back frames with consumer ready
    frame(4'b1011, 1'b1, 1'b1, 1'b0);
    chk("f1_dout", dout, 4'b1011);
    chk("f1_valid", dout_valid, 1);
    frame(4'b0101, 1'b1, 1'b1, 1'b0);
    chk("f2_dout", dout, 4'b0101);
    chk("f2_valid", dout_valid, 1);
    send_bit(1'b0);
    chk("f2_consumed", dout_valid, 0);
    for (int i = 0; i < 4; i++) send_bit(i == 0 || i == 2 ? 1'b0 : 1'b1);
`ifdef SIPO_PARITY_EN
    send_bit(1'b0);
`endif
    send_bit(1'b1);
    chk("f3_dout", dout, 4'b1010);
    chk("f3_valid", dout_valid, 1);
    send_bit(1'b1);
    chk("f3_consumed", dout_valid, 0);
    // 3: overrun while holding, then commit on the draining edge
    frame(4'b0001, 1'b1, 1'b0, 1'b0);
    chk("hold_dout", dout, 4'b0001);
    chk("hold_valid", dout_valid, 1);
    chk("hold_ovr", overrun, 0);
    frame(4'b1000, 1'b1, 1'b0, 1'b0);
    chk("ovr_pulse", overrun, 1);
    chk("ovr_dout", dout, 4'b0001);
    chk("ovr_valid", dout_valid, 1);
    send_bit(1'b1);
    chk("ovr_one_cycle", overrun, 0);
    chk("ovr_still_held", dout, 4'b0001);
    frame(4'b0110, 1'b1, 1'b1, 1'b0);
    chk("swap_dout", dout, 4'b0110);
    chk("swap_valid", dout_valid, 1);
    chk("swap_ovr", overrun, 0);
    send_bit(1'b1);
    chk("swap_consumed", dout_valid, 0);
    // asynchronous reset clears outputs before the next posedge
    frame(4'b1100, 1'b1, 1'b0, 1'b0);
    chk("pre_arst_valid", dout_valid, 1);
    #2 res_n = 1'b0;
    #1;
    chk("arst_valid", dout_valid, 0);
    chk("arst_dout", dout, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    res_n = 1'b1;
    // 4: bad stop bit
    frame(4'b0011, 1'b1, 1'b0, 1'b0);
    chk("pre_ferr_dout", dout, 4'b0011);
    frame(4'b0101, 1'b0, 1'b0, 1'b0);
    chk("ferr_pulse", frame_err, 1);
    chk("ferr_valid", dout_valid, 1);
    chk("ferr_dout", dout, 4'b0011);
    send_bit(1'b1);
    chk("ferr_one_cycle", frame_err, 0);
    chk("ferr_idle", busy, 0);
    frame(4'b1111, 1'b1, 1'b1, 1'b0);
    chk("after_ferr_dout", dout, 4'b1111);
    chk("after_ferr_valid", dout_valid, 1);
    // 5: reset mid-frame
    send_bit(1'b1);
    chk("drain_valid", dout_valid, 0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    res_n = 1'b0;
    @(negedge clk);
    res_n = 1'b1;
    chk("mid_rst_busy", busy, 0);
    frame(4'b0110, 1'b1, 1'b1, 1'b0);
    chk("post_rst_dout", dout, 4'b0110);
    chk("post_rst_valid", dout_valid, 1);
    chk("post_rst_errs", {frame_err, par_err, overrun}, 0);
    send_bit(1'b1);
    chk("post_rst_once", dout_valid, 0);
    chk("post_rst_quiet", {frame_err, par_err, overrun}, 0);
`ifdef SIPO_PARITY_EN
    // 6: parity good then bad
    frame(4'b1011, 1'b1, 1'b1, 1'b0);
    chk("par_ok_dout", dout, 4'b1011);
    chk("par_ok_err", par_err, 0);
    send_bit(1'b1);
    frame(4'b1011, 1'b1, 1'b1, 1'b1);
    chk("par_bad_pulse", par_err, 1);
    chk("par_bad_valid", dout_valid, 0);
    send_bit(1'b1);
    chk("par_one_cycle", par_err, 0);
`else
    chk("par_tied", par_err, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
